// File: rtl/idp_seq_pkg.sv
// idp_seq_pkg: micro-op layout, sequencer state encodings and ALU opcodes
// shared by the idp_sequencer slice.
package idp_seq_pkg;

   localparam int UOP_W = 16;

   // Field order mirrors the micro-op word: [15]s_sel [14:12]w_adr [11:9]s_adr [8:6]r_adr [5:2]alu_op [1]w_en [0]last
   typedef struct packed {
      logic       s_sel;
      logic [2:0] w_adr;
      logic [2:0] s_adr;
      logic [2:0] r_adr;
      logic [3:0] alu_op;
      logic       w_en;
      logic       last;
   } uop_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_PASS = 4'h5;
   localparam logic [3:0] ALU_INC  = 4'h6;
   localparam logic [3:0] ALU_DEC  = 4'h7;

endpackage

// File: rtl/idp_prog_ram.sv
// idp_prog_ram: DEPTH x 16 micro-program store, one write port and one
// registered read port; contents are deliberately not reset.
module idp_prog_ram
   import idp_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [UOP_W-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [UOP_W-1:0] rdata_o
);

   logic [UOP_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/idp_sequencer.sv
// idp_sequencer: micro-sequencer stepping the integer data path, 3 cycles per op.
// Define IDP_SEQ_SINGLE_STEP_EN to add step_req_i, which gates each WAIT -> next op advance.
module idp_sequencer
   import idp_seq_pkg::*;
#(
   parameter int PROG_DEPTH = 16,
   parameter int PC_W       = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
`ifdef IDP_SEQ_SINGLE_STEP_EN
   input  logic             step_req_i,
`endif
   input  logic             prog_we_i,
   input  logic [PC_W-1:0]  prog_addr_i,
   input  logic [UOP_W-1:0] prog_data_i,
   input  logic             flag_c_i,
   input  logic             flag_n_i,
   input  logic             flag_z_i,
   output logic             idp_step_o,
   output logic             w_en_o,
   output logic [2:0]       w_adr_o,
   output logic [2:0]       s_adr_o,
   output logic [2:0]       r_adr_o,
   output logic             s_sel_o,
   output logic [3:0]       alu_op_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             overrun_o,
   output logic [2:0]       flags_q_o
);

   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

   logic [2:0]       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   uop_t             fld_q, fld_d;
   logic             step_q, step_d;
   logic             ovr_q, ovr_d;
   logic [2:0]       flags_q, flags_d;
   logic [UOP_W-1:0] rd_data;
   logic             advance;

   idp_prog_ram #(.DEPTH(PROG_DEPTH), .AW(PC_W)) u_ram (
      .clk_i   (clk_i),
      .we_i    (prog_we_i && state_q == ST_IDLE),
      .waddr_i (prog_addr_i),
      .wdata_i (prog_data_i),
      .raddr_i (pc_q),
      .rdata_o (rd_data)
   );

`ifdef IDP_SEQ_SINGLE_STEP_EN
   assign advance = step_req_i || fld_q.last;
`else
   assign advance = 1'b1;
`endif

   // Fields latch at the end of ISSUE, so the step strobe and its fields appear together one cycle later.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fld_d   = fld_q;
      step_d  = 1'b0;
      ovr_d   = ovr_q;
      flags_d = flags_q;
      case (state_q)
         ST_IDLE: begin
            state_d = start_i ? ST_FETCH : ST_IDLE;
            ovr_d   = start_i ? 1'b0 : ovr_q;
         end
         ST_FETCH: state_d = ST_ISSUE;
         ST_ISSUE: begin
            fld_d   = uop_t'(rd_data);
            step_d  = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            flags_d = {flag_c_i, flag_n_i, flag_z_i};
            if (advance) begin
               if (fld_q.last || pc_q == PC_LAST) begin
                  state_d = ST_DONE;
                  ovr_d   = ovr_q | ~fld_q.last;
               end else begin
                  pc_d    = pc_q + PC_W'(1);
                  state_d = ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            pc_d    = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort_i) begin
         state_d = ST_IDLE;
         pc_d    = '0;
         fld_d   = fld_q;
         step_d  = 1'b0;
         ovr_d   = ovr_q;
         flags_d = flags_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         fld_q   <= '0;
         step_q  <= 1'b0;
         ovr_q   <= 1'b0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fld_q   <= fld_d;
         step_q  <= step_d;
         ovr_q   <= ovr_d;
         flags_q <= flags_d;
      end
   end

   assign idp_step_o = step_q;
   assign w_en_o     = step_q & fld_q.w_en;
   assign w_adr_o    = fld_q.w_adr;
   assign s_adr_o    = fld_q.s_adr;
   assign r_adr_o    = fld_q.r_adr;
   assign s_sel_o    = fld_q.s_sel;
   assign alu_op_o   = fld_q.alu_op;
   assign busy_o     = state_q != ST_IDLE;
   assign done_o     = state_q == ST_DONE;
   assign overrun_o  = ovr_q;
   assign flags_q_o  = flags_q;

endmodule

// File: tb/tb_idp_sequencer.sv
// tb_idp_sequencer: scoreboard bench for idp_sequencer; stimulus pushes expected
// step/done events, a negedge monitor pops and compares them.
module tb_idp_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0, abort_i = 1'b0, prog_we_i = 1'b0;
   logic        step_req_i = 1'b1;
   logic [3:0]  prog_addr_i = '0;
   logic [15:0] prog_data_i = '0;
   logic [2:0]  flg_in = '0;
   logic        idp_step_o, w_en_o, s_sel_o, busy_o, done_o, overrun_o;
   logic [2:0]  w_adr_o, s_adr_o, r_adr_o, flags_q_o;
   logic [3:0]  alu_op_o;

   typedef struct {
      bit          is_done;
      int          cyc;
      logic [15:0] op;
      bit          ovr;
      logic [2:0]  flg;
   } exp_t;

   exp_t        q[$];
   logic [15:0] prog_m [16];
   int          checks = 0, fails = 0, cyc = 0, t0 = 0;

   idp_sequencer dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
`ifdef IDP_SEQ_SINGLE_STEP_EN
      .step_req_i(step_req_i),
`endif
      .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i),
      .flag_c_i(flg_in[2]), .flag_n_i(flg_in[1]), .flag_z_i(flg_in[0]),
      .idp_step_o(idp_step_o), .w_en_o(w_en_o), .w_adr_o(w_adr_o), .s_adr_o(s_adr_o),
      .r_adr_o(r_adr_o), .s_sel_o(s_sel_o), .alu_op_o(alu_op_o), .busy_o(busy_o),
      .done_o(done_o), .overrun_o(overrun_o), .flags_q_o(flags_q_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
      end
   endtask

   function automatic logic [15:0] mk(logic ss, logic [2:0] w, logic [2:0] s, logic [2:0] r,
                                      logic [3:0] a, logic we, logic l);
      return {ss, w, s, r, a, we, l};
   endfunction

   // Monitor: every step or done strobe must match the head of the scoreboard.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         exp_t e;
         if (!idp_step_o && w_en_o) chk("w_en_outside_step", w_en_o, 0);
         if (idp_step_o || done_o) begin
            if (q.size() == 0) chk("unexpected_strobe", {idp_step_o, done_o}, 0);
            else begin
               e = q.pop_front();
               chk("strobe_kind", done_o, e.is_done);
               if (e.cyc >= 0) chk("strobe_cycle", cyc - t0, e.cyc);
               if (e.is_done) begin
                  chk("done_overrun", overrun_o, e.ovr);
                  chk("done_flags", flags_q_o, e.flg);
               end else begin
                  chk("s_sel", s_sel_o, e.op[15]);
                  chk("w_adr", w_adr_o, e.op[14:12]);
                  chk("s_adr", s_adr_o, e.op[11:9]);
                  chk("r_adr", r_adr_o, e.op[8:6]);
                  chk("alu_op", alu_op_o, e.op[5:2]);
                  chk("w_en", w_en_o, e.op[1]);
               end
            end
         end
      end
   end

   task automatic load(int a, logic [15:0] d);
      @(negedge clk_i);
      prog_we_i = 1'b1; prog_addr_i = 4'(a); prog_data_i = d; prog_m[a] = d;
      @(negedge clk_i);
      prog_we_i = 1'b0;
   endtask

   task automatic push_step(int i, int c);
      q.push_back('{is_done: 0, cyc: c, op: prog_m[i], ovr: 0, flg: 0});
   endtask

   task automatic push_run(int k, bit ovr, logic [2:0] flg, bit ss);
      for (int i = 0; i < k; i++) push_step(i, (ss && i > 0) ? -1 : 3 * i + 3);
      q.push_back('{is_done: 1, cyc: ss ? -1 : 3 * k + 1, op: 0, ovr: ovr, flg: flg});
   endtask

   // Start pulse; cycle 1 is the cycle after the start edge. Optional same-cycle write.
   task automatic kick(bit we, int a, logic [15:0] d);
      @(negedge clk_i);
      t0 = cyc; start_i = 1'b1;
      if (we) begin prog_we_i = 1'b1; prog_addr_i = 4'(a); prog_data_i = d; prog_m[a] = d; end
      @(negedge clk_i);
      start_i = 1'b0; prog_we_i = 1'b0;
   endtask

   task automatic wait_rel(int n);
      while (cyc - t0 < n) @(negedge clk_i);
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 300 && !done_o; i++) @(negedge clk_i);
      if (!done_o) chk("done_timeout", 0, 1);
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk_i);
      chk("rst_outputs", {idp_step_o, w_en_o, w_adr_o, s_adr_o, r_adr_o, s_sel_o, alu_op_o,
                          done_o, overrun_o, flags_q_o}, 0);
      chk("rst_busy", busy_o, 0);
      rst_ni = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("idle_no_step", idp_step_o, 0);
      end

      // 4-op program, last on op3; start while busy ignored
      load(0, mk(1'b1, 3'd5, 3'd1, 3'd2, 4'h2, 1'b1, 1'b0));
      load(1, mk(1'b0, 3'd3, 3'd4, 3'd6, 4'h9, 1'b0, 1'b0));
      load(2, mk(1'b1, 3'd7, 3'd0, 3'd3, 4'hF, 1'b1, 1'b0));
      load(3, mk(1'b0, 3'd1, 3'd2, 3'd5, 4'h4, 1'b1, 1'b1));
      push_run(4, 0, 3'b000, 0);
      kick(0, 0, 0);
      chk("busy_cycle1", busy_o, 1);
      wait_rel(4);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      wait_done();
      chk("done_cycle", cyc - t0, 13);
      chk("busy_at_done", busy_o, 1);
      @(negedge clk_i);
      chk("busy_fall_14", busy_o, 0);

      // 16 ops without last -> overrun
      for (int i = 0; i < 16; i++)
         load(i, mk(1'(i), 3'(i), 3'(i + 1), 3'(i + 2), 4'(i), 1'(i >> 1), 1'b0));
      push_run(16, 1, 3'b000, 0);
      kick(0, 0, 0);
      wait_done();
      chk("done_cycle_16", cyc - t0, 49);
      repeat (2) @(negedge clk_i);
      chk("overrun_sticky", overrun_o, 1);

      // Same-cycle start and write: FETCH sees new op0; start clears overrun
      prog_m[0] = mk(1'b0, 3'd6, 3'd5, 3'd4, 4'hA, 1'b1, 1'b1);
      push_run(1, 0, 3'b000, 0);
      kick(1, 0, prog_m[0]);
      chk("overrun_cleared", overrun_o, 0);
      wait_done();

      // Abort in ISSUE of second op; write during run ignored
      load(0, mk(1'b1, 3'd5, 3'd1, 3'd2, 4'h2, 1'b1, 1'b0));
      load(3, mk(1'b0, 3'd1, 3'd2, 3'd5, 4'h4, 1'b1, 1'b1));
      push_step(0, 3);
      kick(0, 0, 0);
      wait_rel(2);
      prog_we_i = 1'b1; prog_addr_i = 4'd1; prog_data_i = 16'hFFFF;
      @(negedge clk_i);
      prog_we_i = 1'b0;
      wait_rel(5);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      chk("abort_busy", busy_o, 0);
      chk("abort_no_step", idp_step_o, 0);
      repeat (6) @(negedge clk_i);
      chk("abort_no_done", done_o, 0);
      flg_in = 3'b011;
      push_run(4, 0, 3'b011, 0);
      kick(0, 0, 0);
      wait_done();

      // Async reset mid-run
      push_step(0, 3);
      kick(0, 0, 0);
      wait_rel(4);
      rst_ni = 1'b0;
      #1;
      chk("async_rst_busy", busy_o, 0);
      chk("async_rst_flags", flags_q_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Flag capture, single-step hold when enabled
      flg_in = 3'b101;
`ifdef IDP_SEQ_SINGLE_STEP_EN
      step_req_i = 1'b0;
      push_run(4, 0, 3'b101, 1);
      kick(0, 0, 0);
      wait_rel(9);
      chk("ss_hold_busy", busy_o, 1);
      chk("ss_hold_flags", flags_q_o, 3'b101);
      step_req_i = 1'b1;
`else
      push_run(4, 0, 3'b101, 0);
      kick(0, 0, 0);
`endif
      wait_done();
      @(negedge clk_i);
      chk("flags_q_101", flags_q_o, 3'b101);
      repeat (3) @(negedge clk_i);
      chk("scoreboard_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
